// File: rtl/cp0_vec_if.sv
// Pipeline-side bundle for cp0_vec: mtc0/mfc0 access, M-stage exception inputs and the interrupt request.
// The master side is the pipeline and the slave side is the coprocessor.
interface cp0_vec_if #(
    parameter int N_HWINT = 6
);
    logic               we;
    logic [4:0]         addr;
    logic [31:0]        din;
    logic               bd;
    logic [29:0]        pc;
    logic [4:0]         exc_code;
    logic [31:0]        bad_vaddr;
    logic [N_HWINT-1:0] hw_int;
    logic               eret;
    logic               int_req;
    logic [31:0]        epc;
    logic [31:0]        dout;

    modport master (
        output we, addr, din, bd, pc, exc_code, bad_vaddr, hw_int, eret,
        input  int_req, epc, dout
    );

    modport slave (
        input  we, addr, din, bd, pc, exc_code, bad_vaddr, hw_int, eret,
        output int_req, epc, dout
    );
endinterface

// File: rtl/cp0_vec.sv
// MIPS coprocessor 0: SR, Cause, EPC, PrID, BadVAddr and level/edge hardware interrupt lines.
// Define CP0_TIMER_EN to add the Count/Compare timer, whose TI flag feeds the highest IP bit.
module cp0_vec #(
    parameter int          N_HWINT    = 6,
    parameter logic [5:0]  HW_EDGE    = 6'b000000,
    parameter logic [31:0] PRID_VALUE = 32'h50724944
) (
    input  logic     clk,
    input  logic     reset_n,
    cp0_vec_if.slave bus
);
    localparam int TOP = N_HWINT - 1;

    logic [5:0]  im_reg;
    logic [5:0]  ip_reg;
    logic [5:0]  ip_next;
    logic [5:0]  ip_eff;
    logic [5:0]  impl_mask;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] epc_reg;
    logic [31:0] bad_vaddr_reg;
    logic        ext;
    logic        intr;
    logic        int_req;
    logic        wr_en;
    logic        cause_wr;

    // Per-line IP next state; unimplemented lines are tied off.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_line
            if (gi < N_HWINT) begin : g_impl
                assign impl_mask[gi] = 1'b1;
                if (HW_EDGE[gi]) begin : g_edge
                    logic prev_reg;
                    always_ff @(posedge clk or negedge reset_n) begin
                        if (!reset_n) prev_reg <= 1'b0;
                        else          prev_reg <= bus.hw_int[gi];
                    end
                    // A new rising edge beats a simultaneous mtc0 clear of the same bit.
                    assign ip_next[gi] = (ip_reg[gi] & ~(cause_wr & ~bus.din[10+gi]))
                                       | (bus.hw_int[gi] & ~prev_reg);
                end else begin : g_level
                    assign ip_next[gi] = bus.hw_int[gi];
                end
            end else begin : g_none
                assign impl_mask[gi] = 1'b0;
                assign ip_next[gi]   = 1'b0;
            end
        end
    endgenerate

`ifdef CP0_TIMER_EN
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        ti_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= 32'd0;
            compare_reg <= 32'd0;
            ti_reg      <= 1'b0;
        end else begin
            if (wr_en && bus.addr == 5'd9) count_reg <= bus.din;
            else                           count_reg <= count_reg + 32'd1;
            if (wr_en && bus.addr == 5'd11) begin
                compare_reg <= bus.din;
                ti_reg      <= 1'b0;
            end else if (count_reg == compare_reg) begin
                ti_reg <= 1'b1;
            end
        end
    end

    assign ip_eff = ip_reg | ({5'b0, ti_reg} << TOP);
`else
    assign ip_eff = ip_reg;
`endif

    assign ext      = (|(ip_eff & im_reg)) & ie_reg;
    assign intr     = (bus.exc_code != 5'd0);
    assign int_req  = (ext | intr) & ~exl_reg;
    // eret and exception entry both pre-empt an mtc0 in the same cycle.
    assign wr_en    = bus.we & ~bus.eret & ~int_req;
    assign cause_wr = wr_en & (bus.addr == 5'd13);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_reg        <= 6'd0;
            ip_reg        <= 6'd0;
            exl_reg       <= 1'b0;
            ie_reg        <= 1'b0;
            bd_reg        <= 1'b0;
            exc_code_reg  <= 5'd0;
            epc_reg       <= 32'd0;
            bad_vaddr_reg <= 32'd0;
        end else begin
            ip_reg <= ip_next;
            if (bus.eret) begin
                exl_reg <= 1'b0;
            end else if (int_req) begin
                exl_reg      <= 1'b1;
                bd_reg       <= bus.bd;
                epc_reg      <= bus.bd ? {bus.pc - 30'd1, 2'b00} : {bus.pc, 2'b00};
                exc_code_reg <= ext ? 5'd0 : bus.exc_code;
                if (!ext && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5))
                    bad_vaddr_reg <= bus.bad_vaddr;
            end else if (bus.we) begin
                case (bus.addr)
                    5'd12: begin
                        im_reg  <= bus.din[15:10] & impl_mask;
                        exl_reg <= bus.din[1];
                        ie_reg  <= bus.din[0];
                    end
                    5'd14:   epc_reg <= bus.din;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            5'd8:  bus.dout = bad_vaddr_reg;
`ifdef CP0_TIMER_EN
            5'd9:  bus.dout = count_reg;
            5'd11: bus.dout = compare_reg;
`endif
            5'd12: bus.dout = {16'b0, im_reg, 8'b0, exl_reg, ie_reg};
            5'd13: bus.dout = {bd_reg, 15'b0, ip_eff, 3'b0, exc_code_reg, 2'b0};
            5'd14: bus.dout = epc_reg;
            5'd15: bus.dout = PRID_VALUE;
            default: bus.dout = 32'd0;
        endcase
    end

    assign bus.int_req = int_req;
    assign bus.epc     = epc_reg;
endmodule

// File: tb/tb_cp0_vec.sv
// Bench for cp0_vec: directed steps, then random traffic checked against a register-word model.
// Line 1 is edge-sensitive, the rest are level-sensitive.
module tb_cp0_vec;
    localparam logic [31:0] PRID = 32'h50724944;
    localparam logic [5:0]  EDGE = 6'b000010;

    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    cp0_vec_if #(.N_HWINT(6)) bus();

    cp0_vec #(.N_HWINT(6), .HW_EDGE(EDGE), .PRID_VALUE(PRID)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model keeps whole architectural register words; IP bits live in m_cause[15:10].
    logic [31:0] m_sr, m_cause, m_epc, m_bva, m_count, m_cmp;
    logic        m_ti;
    logic [5:0]  m_prev;
    logic [5:0]  edge_mask = EDGE;
    logic [4:0]  addrs [8] = '{5'd0, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %08h required %08h", tag, obs, exp);
            $error("%s: observed %08h required %08h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_sr = 0; m_cause = 0; m_epc = 0; m_bva = 0;
        m_count = 0; m_cmp = 0; m_ti = 0; m_prev = 0;
    endtask

    function automatic logic [5:0] m_ip();
        return m_cause[15:10] | {m_ti, 5'b0};
    endfunction

    function automatic logic m_ext();
        return (|(m_ip() & m_sr[15:10])) && m_sr[0];
    endfunction

    function automatic logic m_req();
        return (m_ext() || bus.exc_code != 5'd0) && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_cmp;
`endif
            5'd12: return m_sr;
            5'd13: return {m_cause[31:16], m_ip(), m_cause[9:0]};
            5'd14: return m_epc;
            5'd15: return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step();
        logic       req, ext, wr;
        logic [5:0] nip;
        ext = m_ext();
        req = m_req();
        wr  = bus.we && !bus.eret && !req;
        for (int i = 0; i < 6; i++) begin
            if (edge_mask[i])
                nip[i] = (m_cause[10+i] && !(wr && bus.addr == 5'd13 && !bus.din[10+i]))
                         || (bus.hw_int[i] && !m_prev[i]);
            else
                nip[i] = bus.hw_int[i];
        end
`ifdef CP0_TIMER_EN
        begin
            logic [31:0] ncount;
            logic        nti;
            ncount = (wr && bus.addr == 5'd9) ? bus.din : m_count + 32'd1;
            nti    = (wr && bus.addr == 5'd11) ? 1'b0 : ((m_count == m_cmp) ? 1'b1 : m_ti);
            if (wr && bus.addr == 5'd11) m_cmp = bus.din;
            m_count = ncount;
            m_ti    = nti;
        end
`endif
        if (bus.eret) begin
            m_sr[1] = 1'b0;
        end else if (req) begin
            m_sr[1]       = 1'b1;
            m_cause[31]   = bus.bd;
            m_epc         = bus.bd ? {bus.pc - 30'd1, 2'b00} : {bus.pc, 2'b00};
            m_cause[6:2]  = ext ? 5'd0 : bus.exc_code;
            if (!ext && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5)) m_bva = bus.bad_vaddr;
        end else if (bus.we) begin
            if (bus.addr == 5'd12) m_sr  = bus.din & 32'h0000_FC03;
            if (bus.addr == 5'd14) m_epc = bus.din;
        end
        m_cause[15:10] = nip;
        m_prev = bus.hw_int;
    endtask

    task automatic idle();
        bus.we = 0; bus.addr = 0; bus.din = 0; bus.bd = 0; bus.pc = 0;
        bus.exc_code = 0; bus.bad_vaddr = 0; bus.eret = 0;
    endtask

    // One transaction: check combinational outputs before the edge, clock, advance the model.
    task automatic tick(input string tag);
        #1;
        chk({tag, ".int_req"}, 32'(bus.int_req), 32'(m_req()));
        chk({tag, ".epc"}, bus.epc, m_epc);
        chk({tag, ".dout"}, bus.dout, m_read(bus.addr));
        $display("step %-12s we=%b addr=%0d din=%08h eret=%b exc=%0d hw=%06b int_req=%b dout=%08h",
                 tag, bus.we, bus.addr, bus.din, bus.eret, bus.exc_code, bus.hw_int, bus.int_req, bus.dout);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic peek(input logic [4:0] a);
        bus.addr = a;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        bus.hw_int = 6'h3F;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        peek(13);
        chk("rst_int_req", 32'(bus.int_req), 32'd0);
        chk("rst_epc", bus.epc, 32'd0);
        chk("rst_cause", bus.dout, 32'd0);
        peek(12); chk("rst_sr", bus.dout, 32'd0);
        peek(15); chk("rst_prid", bus.dout, PRID);

        reset_n = 1'b1;
        bus.we = 1; bus.addr = 11; bus.din = 32'hFFFF_FFFF;
        tick("release");
        idle();
        peek(13);
        chk("ip_all_set", bus.dout, 32'h0000_FC00);
        chk("im_zero_noreq", 32'(bus.int_req), 32'd0);

        bus.hw_int = 0;
        bus.we = 1; bus.addr = 13; bus.din = 0;
        tick("clr_cause");
        idle(); peek(13); chk("cause_clear", bus.dout, 32'd0);

        // Level interrupt on line 0.
        bus.we = 1; bus.addr = 12; bus.din = 32'h0000_0401;
        tick("sr_wr");
        idle(); peek(12); chk("sr_value", bus.dout, 32'h0000_0401);
        bus.hw_int = 6'b000001; bus.pc = 30'h100;
        tick("hw0_rise");
        chk("lvl_req", 32'(bus.int_req), 32'd1);
        peek(13); chk("lvl_cause", bus.dout, 32'h0000_0400);
        tick("lvl_take");
        chk("lvl_epc", bus.epc, 32'h0000_0400);
        chk("lvl_exl_mask", 32'(bus.int_req), 32'd0);
        peek(12); chk("lvl_exl", bus.dout, 32'h0000_0403);

        // Internal exception in a delay slot.
        bus.hw_int = 0; bus.eret = 1;
        tick("eret1");
        idle();
        bus.pc = 30'h0000_0C01; bus.bd = 1; bus.exc_code = 5'd4; bus.bad_vaddr = 32'h1235;
        #1; chk("exc_req_0lat", 32'(bus.int_req), 32'd1);
        tick("exc4_bd");
        idle();
        chk("exc_epc", bus.epc, 32'h0000_3000);
        peek(13); chk("exc_cause", bus.dout, 32'h8000_0010);
        peek(8);  chk("exc_badva", bus.dout, 32'h0000_1235);
        bus.eret = 1;
        tick("eret2");
        idle();

        // Edge-sensitive line 1.
        bus.hw_int = 6'b000010; tick("pulse");
        bus.hw_int = 0;         tick("pulse_low");
        peek(13); chk("ip11_sticky", 32'(bus.dout[15:10]), 32'h02);
        bus.we = 1; bus.addr = 13; bus.din = 0;
        tick("clr11");
        idle(); peek(13); chk("ip11_cleared", 32'(bus.dout[15:10]), 32'h00);
        bus.we = 1; bus.addr = 13; bus.din = 0; bus.hw_int = 6'b000010;
        tick("clr_vs_edge");
        idle(); peek(13); chk("edge_beats_clr", 32'(bus.dout[15:10]), 32'h02);
        bus.hw_int = 0;

        // eret with a pending interrupt, then exception entry versus mtc0 EPC.
        bus.we = 1; bus.addr = 12; bus.din = 32'h0000_0801;
        tick("sr_im11");
        idle(); #1; chk("im11_req", 32'(bus.int_req), 32'd1);
        tick("take11");
        chk("exl_blocks", 32'(bus.int_req), 32'd0);
        peek(13); chk("pending_kept", 32'(bus.dout[15:10]), 32'h02);
        bus.eret = 1;
        tick("eret_pend");
        idle(); #1; chk("rearm", 32'(bus.int_req), 32'd1);
        peek(12); chk("eret_exl0", bus.dout, 32'h0000_0801);
        bus.pc = 30'h2222; bus.we = 1; bus.addr = 14; bus.din = 32'hDEAD_BEEC;
        tick("req_vs_epc");
        idle();
        chk("hw_epc_wins", bus.epc, 32'h0000_8888);

        // Asynchronous reset mid-operation, no clock edge needed.
        bus.addr = 13;
        reset_n = 1'b0;
        #1;
        chk("arst_epc", bus.epc, 32'd0);
        chk("arst_cause", bus.dout, 32'd0);
        chk("arst_int_req", 32'(bus.int_req), 32'd0);
        peek(12); chk("arst_sr", bus.dout, 32'd0);
        m_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.we = 1; bus.addr = 11; bus.din = 32'hFFFF_FFFF;
        tick("release2");
        idle();

`ifdef CP0_TIMER_EN
        bus.we = 1; bus.addr = 11; bus.din = 32'd5;         tick("cmp5");
        bus.we = 1; bus.addr = 9;  bus.din = 32'd0;         tick("count0");
        bus.we = 1; bus.addr = 12; bus.din = 32'h0000_8001; tick("sr_im15");
        idle();
        bus.addr = 9;
        for (int k = 0; k < 12 && !bus.int_req; k++) tick("timer_run");
        chk("timer_req", 32'(bus.int_req), 32'd1);
        chk("timer_count", bus.dout, 32'd6);
        peek(13); chk("timer_ip15", 32'(bus.dout[15]), 32'd1);
        tick("timer_take");
        bus.we = 1; bus.addr = 11; bus.din = 32'd100;       tick("cmp_clr_ti");
        idle(); peek(13); chk("ti_cleared", 32'(bus.dout[15]), 32'd0);
        bus.eret = 1; tick("eret_t");
        idle();
        bus.we = 1; bus.addr = 12; bus.din = 0; tick("sr_zero");
        idle();
`endif

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            int r;
            bus.we        = ($urandom_range(0, 3) == 0);
            bus.addr      = addrs[$urandom_range(0, 7)];
            bus.din       = $urandom;
            bus.bd        = 1'($urandom_range(0, 1));
            bus.pc        = 30'($urandom);
            bus.bad_vaddr = $urandom;
            r = $urandom_range(0, 9);
            bus.exc_code  = (r == 0) ? 5'd4 : (r == 1) ? 5'd5 :
                            (r == 2) ? 5'($urandom_range(1, 31)) : 5'd0;
            if ($urandom_range(0, 2) == 0) bus.hw_int = 6'($urandom);
            bus.eret      = ($urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
